riscv_lsu: RTL and testbench
============================

// Module: riscv_lsu
// PURPOSE
//  Load/store unit for the next-generation riscv_cpu. Replaces the zero-wait-state ReadData/Mem_WrData path.
//  Sits between datapath and data memory. Converts one core request (funct3 type) into a valid/ready bus
//  transaction with byte strobes, extracts/sign-extends loads, stalls the core until done, and flags
//  misaligned, illegal or timed-out accesses.
// PARAMETERS
//  ADDR_W          32   byte-address width on core and bus side (data width fixed at 32)
//  TIMEOUT         255  max BUS-state cycles before abort; 0 = never time out
//  ERR_ON_MISALIGN 1    1: misaligned access -> rsp_err, no bus cycle; 0: low addr bits forced to 0, access proceeds
// PORTS
//  clk         in   1       clock, all state on rising edge
//  reset       in   1       asynchronous, active-low reset
//  req_valid   in   1       core requests access; held with all req_* stable until rsp_valid
//  req_write   in   1       1 = store, 0 = load
//  req_type    in   3       funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data (rs2), right-justified
//  stall       out  1       freeze PC/pipeline regs this cycle
//  rsp_valid   out  1       one-cycle pulse: load data valid / store committed / error
//  rsp_rdata   out  32      extended load data; 0 for stores and errors
//  rsp_err     out  1       qualifies rsp_valid: misaligned, illegal type or timeout
//  mem_valid   out  1       bus request
//  mem_ready   in   1       bus accept/complete (read data valid same cycle)
//  mem_we      out  1       bus write
//  mem_addr    out  ADDR_W  word-aligned address (bits [1:0] = 0)
//  mem_wstrb   out  4       byte enables
//  mem_wdata   out  32      lane-steered store data
//  mem_rdata   in   32      bus read data
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, timer 0; all outputs 0. Reset mid-transaction drops mem_valid at once,
//   no response is issued.
//  FSM IDLE -> BUS -> RESP -> IDLE; error path IDLE -> RESP.
//  IDLE: on req_valid, decode. Illegal type (011,110,111; any of 100/101 with req_write) or misaligned
//   (H: addr[0]!=0; W: addr[1:0]!=0) with ERR_ON_MISALIGN=1 -> RESP with err. Else latch addr/we/wstrb/wdata -> BUS.
//  BUS: mem_valid=1; mem_* registered, stable until mem_ready. On mem_ready: capture extended rdata -> RESP.
//   Timer counts BUS cycles. If TIMEOUT!=0 and timer==TIMEOUT with no ready -> RESP with err, mem_valid drops.
//   mem_ready and timeout in the same cycle: ready wins.
//  RESP: rsp_valid=1 for one cycle, rsp_err/rsp_rdata valid -> IDLE. No request accepted in RESP.
//  stall = req_valid & (state != RESP). Core advances on the RESP cycle.
//  Latency: zero-wait bus -> rsp_valid 2 cycles after req_valid first seen in IDLE; +1 per wait cycle.
//   Error path: 1 cycle.
//  Store steering: B -> wdata={4{b}}, wstrb=0001<<a[1:0]; H -> {2{h}}, wstrb=0011<<(2*a[1]); W -> wdata, 1111.
//  Load extract: byte/half selected by a[1:0]/a[1]; B,H sign-extend; BU,HU zero-extend; W passthrough.
//  ERR_ON_MISALIGN=0: a[0] (H) / a[1:0] (W) treated as 0 for strobes and extraction.
//  req_valid dropped while in BUS: bus cycle still completes and rsp_valid still pulses (protocol integrity).
//  mem_valid never deasserts in BUS without mem_ready or timeout.
// STRUCTURE
//  Shared package riscv_pkg: funct3 load/store constants (LS_B, LS_H, LS_W, LS_BU, LS_HU);
//   LSU state encoding (LSU_IDLE, LSU_BUS, LSU_RESP).
//  One combinational sub-module: lsu_load_extend (rdata, addr[1:0], type -> 32-bit result), reused by datapath.
//  Steering, FSM and timer stay in riscv_lsu.
// TESTING
//  1 LW 0x100, mem_ready same cycle, rdata=0xDEADBEEF -> rsp_valid 2 cycles after req, rdata 0xDEADBEEF,
//    stall high 2 cycles.
//  2 LB 0x103, rdata=0x80FF_0000 -> 0xFFFFFF80; LBU -> 0x00000080; LH 0x102 -> 0xFFFF80FF; LHU -> 0x000080FF.
//  3 SB 0x201 wdata=0x123456AB -> mem_addr 0x200, wstrb 0010, wdata 0xABABABAB; SH 0x202 -> wstrb 1100,
//    wdata 0x56AB56AB.
//  4 LW 0x102 (ERR_ON_MISALIGN=1) -> no mem_valid, rsp_valid+rsp_err next cycle; with =0 -> mem_addr 0x100, no err.
//  5 TIMEOUT=4, mem_ready held 0 -> mem_valid 4 cycles then 0, rsp_err pulse; 3 wait states then ready ->
//    normal response, mem_* stable throughout.
//  6 reset=0 during BUS -> mem_valid, stall, rsp_valid 0 immediately; after release next LW completes normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: load/store funct3 encodings and LSU state encoding.
// Used by the LSU and by datapath logic that decodes memory instructions.
package riscv_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_extend.sv
// Load extraction: picks the byte or half selected by the address offset, then sign- or zero-extends it.
// Purely combinational, no flow control.
module lsu_load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  ls_type,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = rdata >> {off, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (ls_type)
      LS_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LS_BU:   result = {24'h0, byte_sel};
      LS_H:    result = {{16{half_sel[15]}}, half_sel};
      LS_HU:   result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one core request -> one valid/ready bus transaction; response 2 cycles after request on a
// zero-wait bus (+1 per wait state, 1 cycle for errors). Stalls the core until the response; bus waits hold mem_* stable.
module riscv_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int TIMEOUT         = 255,
  parameter int ERR_ON_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        type_q, type_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        illegal, misaligned, is_h, is_w;
  logic [1:0]  off;
  logic [3:0]  strb;
  logic [31:0] steered, ext_rdata;

  lsu_load_extend u_load_extend (
    .rdata   (mem_rdata),
    .off     (off_q),
    .ls_type (type_q),
    .result  (ext_rdata)
  );

  // Decode and lane steering of the incoming request; the offset is already
  // aligned for H/W so relaxed-misalign mode steers as if the low bits were 0.
  always_comb begin
    is_h       = (req_type[1:0] == 2'b01);
    is_w       = (req_type == LS_W);
    illegal    = (req_type == 3'b011) || (req_type[2:1] == 2'b11) || (req_write && req_type[2]);
    misaligned = (is_h && req_addr[0]) || (is_w && (req_addr[1:0] != 2'b00));
    off        = is_w ? 2'b00 : (is_h ? {req_addr[1], 1'b0} : req_addr[1:0]);
    case (req_type)
      LS_B:    begin strb = 4'b0001 << off; steered = {4{req_wdata[7:0]}};  end
      LS_H:    begin strb = 4'b0011 << off; steered = {2{req_wdata[15:0]}}; end
      default: begin strb = 4'b1111;        steered = req_wdata;            end
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    type_d  = type_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: begin
        timer_d = '0;
        if (req_valid) begin
          if (illegal || ((ERR_ON_MISALIGN != 0) && misaligned)) begin
            state_d = LSU_RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = LSU_BUS;
            timer_d = TW'(1);
            addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            we_d    = req_write;
            wstrb_d = req_write ? strb : 4'b0000;
            wdata_d = req_write ? steered : 32'h0;
            type_d  = req_type;
            off_d   = off;
          end
        end
      end
      LSU_BUS: begin
        // Ready is checked first so a completion on the last allowed cycle is not lost.
        if (mem_ready) begin
          state_d = LSU_RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : ext_rdata;
        end else if ((TIMEOUT != 0) && (timer_q == TW'(TIMEOUT))) begin
          state_d = LSU_RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else if (TIMEOUT != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
        err_d   = 1'b0;
        rdata_d = 32'h0;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LSU_IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      type_q  <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      type_q  <= type_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_valid = (state_q == LSU_BUS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = (state_q == LSU_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  // Gated by reset so the core is released immediately when reset asserts.
  assign stall     = reset && req_valid && (state_q != LSU_RESP);

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: a strict instance (TIMEOUT=4, misalign errors) and a relaxed one (no timeout, misalign masked).
module tb_riscv_lsu;

  localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0, req_valid = 1'b0, req_write = 1'b0, mem_ready = 1'b0;
  logic [2:0]  req_type = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, mem_rdata = 32'h0;

  logic        a_stall, a_rsp_valid, a_rsp_err, a_mem_valid, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic        b_stall, b_rsp_valid, b_rsp_err, b_mem_valid, b_mem_we;
  logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wstrb;

  riscv_lsu #(.ADDR_W(32), .TIMEOUT(4), .ERR_ON_MISALIGN(1)) dut (
    .clk(clk), .reset(rst_n), .req_valid(req_valid & ~sel), .req_write(req_write), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(a_stall), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .mem_valid(a_mem_valid), .mem_ready(mem_ready),
    .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  riscv_lsu #(.ADDR_W(32), .TIMEOUT(0), .ERR_ON_MISALIGN(0)) dut_relaxed (
    .clk(clk), .reset(rst_n), .req_valid(req_valid & sel), .req_write(req_write), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(b_stall), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .mem_valid(b_mem_valid), .mem_ready(mem_ready),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic        o_stall, o_rsp_valid, o_rsp_err, o_mem_valid, o_mem_we;
  logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  assign o_stall     = sel ? b_stall     : a_stall;
  assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign o_mem_valid = sel ? b_mem_valid : a_mem_valid;
  assign o_mem_we    = sel ? b_mem_we    : a_mem_we;
  assign o_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign o_mem_wstrb = sel ? b_mem_wstrb : a_mem_wstrb;
  assign o_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;

  int n_cmp = 0, n_bad = 0;
  logic [32:0] sb[$];  // expected {rsp_err, rsp_rdata}

  // Observations from the most recent transaction.
  int          r_lat, r_nmem, r_nstall;
  logic [31:0] r_rdata, r_addr, r_wdata;
  logic [3:0]  r_strb;
  logic        r_err, r_we;
  bit          r_stable;

  // Drives one request, acts as a bus slave inserting 'waits' wait states, and records what the DUT did.
  task automatic run_txn(input bit s, input bit w, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input logic [31:0] rd, input bit drop);
    sel = s; req_write = w; req_type = t; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    r_lat = -1; r_nmem = 0; r_nstall = 0; r_stable = 1'b1;
    r_rdata = 'x; r_err = 'x; r_addr = 'x; r_strb = 'x; r_wdata = 'x; r_we = 'x;
    for (int k = 0; k < 40 && r_lat < 0; k++) begin
      @(negedge clk);
      if (o_stall) r_nstall++;
      if (o_rsp_valid) begin
        r_lat = k; r_rdata = o_rsp_rdata; r_err = o_rsp_err; req_valid = 1'b0;
      end
      if (o_mem_valid) begin
        if (r_nmem == 0) begin
          r_we = o_mem_we; r_addr = o_mem_addr; r_strb = o_mem_wstrb; r_wdata = o_mem_wdata;
        end else if ({o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata} !== {r_we, r_addr, r_strb, r_wdata}) begin
          r_stable = 1'b0;
        end
        r_nmem++;
        mem_ready = (r_nmem > waits);
        mem_rdata = mem_ready ? rd : 32'h0;
        if (drop) req_valid = 1'b0;
      end else begin
        mem_ready = 1'b0; mem_rdata = 32'h0;
      end
    end
    req_valid = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_type = T_W; req_addr = 32'h100;
    repeat (2) @(negedge clk);
    n_cmp++; if ({a_stall, a_mem_valid, a_mem_we, a_rsp_valid, a_rsp_err} !== 5'b0) begin n_bad++; $display("FAIL reset_ctrl got %b required 00000", {a_stall, a_mem_valid, a_mem_we, a_rsp_valid, a_rsp_err}); end
    n_cmp++; if (a_rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h required 0", a_rsp_rdata); end
    n_cmp++; if ({a_mem_addr, a_mem_wstrb, a_mem_wdata} !== 68'h0) begin n_bad++; $display("FAIL reset_bus got %h/%b/%h required 0", a_mem_addr, a_mem_wstrb, a_mem_wdata); end
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    logic [32:0] e;
    sb.push_back({1'b0, 32'hDEADBEEF});
    run_txn(0, 0, T_W, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0);
    e = sb.pop_front();
    n_cmp++; if ({r_err, r_rdata} !== e) begin n_bad++; $display("FAIL lw_rsp got %h required %h", {r_err, r_rdata}, e); end
    n_cmp++; if (r_lat !== 2) begin n_bad++; $display("FAIL lw_latency got %0d required 2", r_lat); end
    n_cmp++; if (r_nstall !== 2) begin n_bad++; $display("FAIL lw_stall_cycles got %0d required 2", r_nstall); end
    n_cmp++; if ({r_nmem, r_we, r_addr} !== {32'd1, 1'b0, 32'h100}) begin n_bad++; $display("FAIL lw_bus got n=%0d we=%b addr=%h required n=1 we=0 addr=100", r_nmem, r_we, r_addr); end
  endtask

  task automatic test_load_extend();
    logic [2:0]  ty [6] = '{T_B, T_BU, T_H, T_HU, T_B, T_H};
    logic [31:0] ad [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
    logic [31:0] rd [6] = '{32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000, 32'h0000007F, 32'h12348001};
    logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h0000007F, 32'hFFFF8001};
    logic [32:0] e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back({1'b0, ex[i]});
      run_txn(0, 0, ty[i], ad[i], 32'h0, 0, rd[i], 0);
      e = sb.pop_front();
      n_cmp++; if ({r_err, r_rdata} !== e) begin n_bad++; $display("FAIL load_ext[%0d] got %h required %h", i, {r_err, r_rdata}, e); end
      n_cmp++; if (r_addr !== 32'h100) begin n_bad++; $display("FAIL load_ext_addr[%0d] got %h required 100", i, r_addr); end
    end
  endtask

  task automatic test_store();
    logic [2:0]  ty [5] = '{T_B, T_H, T_W, T_B, T_H};
    logic [31:0] ad [5] = '{32'h201, 32'h202, 32'h204, 32'h203, 32'h200};
    logic [31:0] wd [5] = '{32'h123456AB, 32'h123456AB, 32'h123456AB, 32'h000000C3, 32'hFFFF1357};
    logic [31:0] ea [5] = '{32'h200, 32'h200, 32'h204, 32'h200, 32'h200};
    logic [3:0]  es [5] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000, 4'b0011};
    logic [31:0] ew [5] = '{32'hABABABAB, 32'h56AB56AB, 32'h123456AB, 32'hC3C3C3C3, 32'h13571357};
    logic [32:0] e;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(33'h0);
      run_txn(0, 1, ty[i], ad[i], wd[i], 0, 32'hFFFFFFFF, 0);
      e = sb.pop_front();
      n_cmp++; if ({r_err, r_rdata, r_lat} !== {e, 32'd2}) begin n_bad++; $display("FAIL store_rsp[%0d] got %h lat %0d required %h lat 2", i, {r_err, r_rdata}, r_lat, e); end
      n_cmp++; if ({r_we, r_addr, r_strb, r_wdata} !== {1'b1, ea[i], es[i], ew[i]}) begin n_bad++; $display("FAIL store_bus[%0d] got we=%b %h %b %h required we=1 %h %b %h", i, r_we, r_addr, r_strb, r_wdata, ea[i], es[i], ew[i]); end
    end
  endtask

  task automatic test_errors();
    bit          wr [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  ty [7] = '{T_W, T_H, T_H, 3'b011, T_BU, 3'b111, T_W};
    logic [31:0] ad [7] = '{32'h102, 32'h201, 32'h101, 32'h100, 32'h100, 32'h100, 32'h203};
    logic [32:0] e;
    for (int i = 0; i < 7; i++) begin
      sb.push_back({1'b1, 32'h0});
      run_txn(0, wr[i], ty[i], ad[i], 32'h12345678, 0, 32'hA5A5A5A5, 0);
      e = sb.pop_front();
      n_cmp++; if ({r_err, r_rdata} !== e) begin n_bad++; $display("FAIL err_rsp[%0d] got %h required %h", i, {r_err, r_rdata}, e); end
      n_cmp++; if ({r_lat, r_nmem} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL err_path[%0d] got lat=%0d bus_cycles=%0d required lat=1 bus_cycles=0", i, r_lat, r_nmem); end
    end
  endtask

  task automatic test_relaxed();
    bit          wr [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  ty [4] = '{T_W, T_H, T_W, T_H};
    logic [31:0] ad [4] = '{32'h102, 32'h103, 32'h203, 32'h201};
    logic [31:0] wd [4] = '{32'h0, 32'h0, 32'h89ABCDEF, 32'h0000BEEF};
    logic [31:0] rd [4] = '{32'hCAFEF00D, 32'h80010000, 32'h0, 32'h0};
    logic [31:0] ex [4] = '{32'hCAFEF00D, 32'hFFFF8001, 32'h0, 32'h0};
    logic [31:0] ea [4] = '{32'h100, 32'h100, 32'h200, 32'h200};
    logic [3:0]  es [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b0011};
    logic [31:0] ew [4] = '{32'h0, 32'h0, 32'h89ABCDEF, 32'hBEEFBEEF};
    logic [32:0] e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back({1'b0, ex[i]});
      run_txn(1, wr[i], ty[i], ad[i], wd[i], 0, rd[i], 0);
      e = sb.pop_front();
      n_cmp++; if ({r_err, r_rdata, r_lat} !== {e, 32'd2}) begin n_bad++; $display("FAIL relaxed_rsp[%0d] got %h lat %0d required %h lat 2", i, {r_err, r_rdata}, r_lat, e); end
      n_cmp++; if (r_addr !== ea[i]) begin n_bad++; $display("FAIL relaxed_addr[%0d] got %h required %h", i, r_addr, ea[i]); end
      if (wr[i]) begin
        n_cmp++; if ({r_strb, r_wdata} !== {es[i], ew[i]}) begin n_bad++; $display("FAIL relaxed_store[%0d] got %b %h required %b %h", i, r_strb, r_wdata, es[i], ew[i]); end
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_timeout();
    int          wt [3] = '{1000, 3, 2};
    logic [32:0] ex [3] = '{{1'b1, 32'h0}, {1'b0, 32'h55AA1234}, {1'b0, 32'h55AA1234}};
    int          el [3] = '{5, 5, 4};
    int          en [3] = '{4, 4, 3};
    logic [32:0] e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ex[i]);
      run_txn(0, 0, T_W, 32'h300, 32'h0, wt[i], 32'h55AA1234, 0);
      e = sb.pop_front();
      n_cmp++; if ({r_err, r_rdata} !== e) begin n_bad++; $display("FAIL timeout_rsp[%0d] got %h required %h", i, {r_err, r_rdata}, e); end
      n_cmp++; if ({r_lat, r_nmem} !== {el[i], en[i]}) begin n_bad++; $display("FAIL timeout_cycles[%0d] got lat=%0d bus=%0d required lat=%0d bus=%0d", i, r_lat, r_nmem, el[i], en[i]); end
      n_cmp++; if (r_stable !== 1'b1) begin n_bad++; $display("FAIL timeout_stable[%0d] got %b required 1", i, r_stable); end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e;
    sb.push_back({1'b0, 32'h11111111});
    sb.push_back(33'h0);
    sb.push_back({1'b0, 32'h000000AB});
    run_txn(0, 0, T_W, 32'h10, 32'h0, 0, 32'h11111111, 0);
    e = sb.pop_front();
    n_cmp++; if ({r_err, r_rdata, r_lat} !== {e, 32'd2}) begin n_bad++; $display("FAIL b2b_load0 got %h lat %0d required %h lat 2", {r_err, r_rdata}, r_lat, e); end
    // Request withdrawn mid-bus-cycle: the store still completes and responds.
    run_txn(0, 1, T_W, 32'h14, 32'h22222222, 1, 32'h0, 1);
    e = sb.pop_front();
    n_cmp++; if ({r_err, r_rdata, r_lat, r_nmem} !== {e, 32'd3, 32'd2}) begin n_bad++; $display("FAIL b2b_drop got %h lat %0d bus %0d required %h lat 3 bus 2", {r_err, r_rdata}, r_lat, r_nmem, e); end
    n_cmp++; if ({r_strb, r_wdata, r_stable} !== {4'b1111, 32'h22222222, 1'b1}) begin n_bad++; $display("FAIL b2b_drop_bus got %b %h %b required 1111 22222222 1", r_strb, r_wdata, r_stable); end
    run_txn(0, 0, T_BU, 32'h11, 32'h0, 0, 32'h0000AB00, 0);
    e = sb.pop_front();
    n_cmp++; if ({r_err, r_rdata, r_lat} !== {e, 32'd2}) begin n_bad++; $display("FAIL b2b_load1 got %h lat %0d required %h lat 2", {r_err, r_rdata}, r_lat, e); end
  endtask

  task automatic test_mid_reset();
    int          stray;
    logic [32:0] e;
    sel = 1'b0; req_write = 1'b0; req_type = T_W; req_addr = 32'h400; req_valid = 1'b1; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_mem_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_busy got %b required 1", a_mem_valid); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({a_mem_valid, a_stall, a_rsp_valid} !== 3'b000) begin n_bad++; $display("FAIL midrst_drop got %b required 000", {a_mem_valid, a_stall, a_rsp_valid}); end
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    stray = 0;
    repeat (4) begin @(negedge clk); if (a_rsp_valid) stray++; end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL midrst_no_rsp got %0d required 0", stray); end
    @(posedge clk); #1;
    sb.push_back({1'b0, 32'h0BADCAFE});
    run_txn(0, 0, T_W, 32'h100, 32'h0, 0, 32'h0BADCAFE, 0);
    e = sb.pop_front();
    n_cmp++; if ({r_err, r_rdata, r_lat} !== {e, 32'd2}) begin n_bad++; $display("FAIL midrst_after got %h lat %0d required %h lat 2", {r_err, r_rdata}, r_lat, e); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_errors();
    test_relaxed();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
